// File: rtl/mul16_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mul16_sequencer
// Purpose  : Multi-cycle unsigned 16x16 shift-and-add multiplier returning the
//            low 16 product bits plus an exact overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module mul16_sequencer #(
    parameter int EARLY_EXIT = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] out,
    output logic        ovf
);

    localparam logic c_early_exit = (EARLY_EXIT != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_mcand;
    logic [15:0] r_mplier;
    logic [15:0] r_acc;
    logic [3:0]  r_count;
    logic        r_lost;
    logic        r_ovfacc;
    logic [15:0] r_out;
    logic        r_ovf;

    logic [15:0] w_pp;
    logic [16:0] w_sum;
    logic        w_ovf_step;
    logic        w_early;
    logic        w_last;

    // r_lost remembers that a multiplicand bit has already shifted past bit 15,
    // so any later selected partial product would reach weight 2^16 or above.
    assign w_pp       = r_mcand & {16{r_mplier[0]}};
    assign w_sum      = {1'b0, r_acc} + {1'b0, w_pp};
    assign w_ovf_step = r_ovfacc | w_sum[16] | (r_mplier[0] & r_lost);
    assign w_early    = c_early_exit && (r_mplier == 16'd0);
    assign w_last     = (r_count == 4'd15);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_RUN;
            ST_RUN:  if (w_early || w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mcand  <= 16'd0;
            r_mplier <= 16'd0;
            r_acc    <= 16'd0;
            r_count  <= 4'd0;
            r_lost   <= 1'b0;
            r_ovfacc <= 1'b0;
            r_out    <= 16'd0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_acc    <= 16'd0;
                        r_count  <= 4'd0;
                        r_lost   <= 1'b0;
                        r_ovfacc <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_early) begin
                        r_out <= r_acc;
                        r_ovf <= r_ovfacc;
                    end else begin
                        r_acc    <= w_sum[15:0];
                        r_ovfacc <= w_ovf_step;
                        r_lost   <= r_lost | r_mcand[15];
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_count  <= r_count + 4'd1;
                        if (w_last) begin
                            r_out <= w_sum[15:0];
                            r_ovf <= w_ovf_step;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);
    assign out  = r_out;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mul16_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul16_sequencer
// Purpose  : Scoreboard bench for mul16_sequencer, fixed-length and early-exit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul16_sequencer;

    logic        clk;
    logic        rst;
    logic        start0, start1;
    logic [15:0] a0, b0, a1, b1;
    logic        busy0, done0, ovf0, busy1, done1, ovf1;
    logic [15:0] out0, out1;

    int n_cmp;
    int n_fail;
    logic [16:0] q0[$];
    logic [16:0] q1[$];

    mul16_sequencer #(.EARLY_EXIT(0)) dut0 (
        .clock(clk), .reset(rst), .start(start0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .out(out0), .ovf(ovf0)
    );

    mul16_sequencer #(.EARLY_EXIT(1)) dut1 (
        .clock(clk), .reset(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .out(out1), .ovf(ovf1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] p;
        p = {16'd0, x} * {16'd0, y};
        return {(p[31:16] != 16'd0), p[15:0]};
    endfunction

    // One operation on the selected instance; starts and ends on a falling edge.
    task automatic do_op(input bit sel, input logic [15:0] ta, input logic [15:0] tb,
                         input int lat, input string nm);
        int          cyc;
        bit          seen;
        logic [16:0] exp_v;
        logic [16:0] got;
        exp_v = model(ta, tb);
        if (sel) begin q1.push_back(exp_v); start1 = 1'b1; a1 = ta; b1 = tb; end
        else     begin q0.push_back(exp_v); start0 = 1'b1; a0 = ta; b0 = tb; end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        n_cmp++;
        if ((sel ? busy1 : busy0) !== 1'b1 || (sel ? done1 : done0) !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_after_start: busy=%b done=%b, required busy=1 done=0", nm,
                     sel ? busy1 : busy0, sel ? done1 : done0);
        end
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if ((sel ? done1 : done0) === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || cyc != lat) begin
            n_fail++;
            $display("FAIL %s latency: done after %0d edges (seen=%b), required %0d", nm, cyc, seen, lat);
        end
        if (seen) begin
            got = sel ? {ovf1, out1} : {ovf0, out0};
            exp_v = sel ? (q1.size() > 0 ? q1.pop_front() : 17'h1ffff)
                        : (q0.size() > 0 ? q0.pop_front() : 17'h1ffff);
            n_cmp++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL %s result: out=%h ovf=%b, required out=%h ovf=%b", nm,
                         got[15:0], got[16], exp_v[15:0], exp_v[16]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ((sel ? done1 : done0) !== 1'b0 || (sel ? busy1 : busy0) !== 1'b0) begin
            n_fail++;
            $display("FAIL %s return_idle: done=%b busy=%b, required 0 0", nm,
                     sel ? done1 : done0, sel ? busy1 : busy0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start0 = 1'b0; start1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        #1 rst = 1'b1;
        #2;
        n_cmp++;
        if ({busy0, done0, out0, ovf0, busy1, done1, out1, ovf1} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy0=%b done0=%b out0=%h ovf0=%b busy1=%b done1=%b out1=%h ovf1=%b, required all 0",
                     busy0, done0, out0, ovf0, busy1, done1, out1, ovf1);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_op(1'b0, 16'd3, 16'd5, 16, "mul_3x5");
    endtask

    task automatic test_overflow();
        do_op(1'b0, 16'h0100, 16'h0100, 16, "mul_100x100");
        do_op(1'b0, 16'hFFFF, 16'h0001, 16, "mul_ffffx1");
        do_op(1'b0, 16'hFFFF, 16'h0002, 16, "mul_ffffx2");
        do_op(1'b0, 16'h8001, 16'h8001, 16, "mul_8001x8001");
    endtask

    task automatic test_early_exit();
        do_op(1'b1, 16'd7, 16'd3, 3, "ee_7x3");
        do_op(1'b1, 16'd1234, 16'd0, 1, "ee_1234x0");
        do_op(1'b1, 16'h4000, 16'h0009, 5, "ee_4000x9");
    endtask

    task automatic test_ignore_start();
        int   cyc;
        int   pulses;
        bit   seen;
        logic [16:0] exp_v;
        q0.push_back(model(16'd2, 16'd3));
        start0 = 1'b1; a0 = 16'd2; b0 = 16'd3;
        @(negedge clk);
        a0 = 16'd9; b0 = 16'd9;
        cyc = 0; seen = 1'b0; pulses = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done0 === 1'b1) seen = 1'b1;
        end
        start0 = 1'b0;
        if (seen) pulses = 1;
        exp_v = (q0.size() > 0) ? q0.pop_front() : 17'h1ffff;
        n_cmp++;
        if ({ovf0, out0} !== exp_v || cyc != 16) begin
            n_fail++;
            $display("FAIL ignore_start result: out=%h ovf=%b after %0d edges, required out=%h ovf=%b after 16",
                     out0, ovf0, cyc, exp_v[15:0], exp_v[16]);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done0 === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL ignore_start pulses: %0d done pulses, required 1", pulses);
        end
    endtask

    task automatic test_async_reset();
        do_op(1'b0, 16'd3, 16'd5, 16, "pre_reset_3x5");
        n_cmp++;
        if (out0 !== 16'd15) begin
            n_fail++;
            $display("FAIL pre_reset_out: out=%h, required 000f", out0);
        end
        start0 = 1'b1; a0 = 16'd7; b0 = 16'd7;
        @(negedge clk);
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy0, done0, out0, ovf0} !== 19'd0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b done=%b out=%h ovf=%b, required all 0",
                     busy0, done0, out0, ovf0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op(1'b0, 16'd4, 16'd4, 16, "post_reset_4x4");
    endtask

    task automatic test_back_to_back();
        int   cyc;
        int   ndone;
        int   last_done;
        logic prev_busy;
        logic [16:0] exp_v;
        start0 = 1'b1; a0 = 16'd5; b0 = 16'd6;
        cyc = 0; ndone = 0; last_done = 0; prev_busy = busy0;
        while (ndone < 3 && cyc < 70) begin
            @(negedge clk);
            cyc++;
            if (busy0 === 1'b1 && prev_busy === 1'b0) q0.push_back(model(16'd5, 16'd6));
            prev_busy = busy0;
            if (done0 === 1'b1) begin
                exp_v = (q0.size() > 0) ? q0.pop_front() : 17'h1ffff;
                n_cmp++;
                if ({ovf0, out0} !== exp_v) begin
                    n_fail++;
                    $display("FAIL b2b result %0d: out=%h ovf=%b, required out=%h ovf=%b",
                             ndone, out0, ovf0, exp_v[15:0], exp_v[16]);
                end
                if (ndone > 0) begin
                    n_cmp++;
                    if (cyc - last_done != 18) begin
                        n_fail++;
                        $display("FAIL b2b spacing %0d: %0d cycles, required 18", ndone, cyc - last_done);
                    end
                end
                last_done = cyc;
                ndone++;
            end
        end
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (ndone != 3 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b count: %0d done pulses busy=%b, required 3 and idle", ndone, busy0);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_early_exit();
        test_ignore_start();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
